// File: rtl/sine_dds_core_if.sv
// sine_dds_core_if: byte-wide configuration bus plus the sample stream of the sine DDS core.
interface sine_dds_core_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [7:0] sample;
  logic       sample_valid;
  logic       running;

  modport master (
    output cfg_valid, cfg_addr, cfg_data,
    input  cfg_ready, sample, sample_valid, running
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data,
    output cfg_ready, sample, sample_valid, running
  );
endinterface

// File: rtl/sine_dds_core.sv
// sine_dds_core: 16-bit phase accumulator driving a quarter-wave sine table through a
// three-stage valid-tagged pipeline, producing offset-binary samples around mid-scale 128.
module sine_dds_core #(
  parameter int ACC_W  = 16,
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  sine_dds_core_if.slave bus
);

  localparam int PH_W  = LUT_AW + 2;
  localparam int MAG_W = OUT_W - 1;
  localparam logic [1:0] ADDR_FTW_LO = 2'd0;
  localparam logic [1:0] ADDR_FTW_HI = 2'd1;
  localparam logic [1:0] ADDR_PHASE  = 2'd2;
  localparam logic [OUT_W-1:0] MID_SCALE = OUT_W'(1 << (OUT_W - 1));

  logic              cfg_ready_q;
  logic              wr_en;
  logic              clr_req;
  logic [7:0]        ftw_lo_q;
  logic [ACC_W-1:0]  ftw_q;
  logic [PH_W-1:0]   phase_ofs_q;
  logic              run_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [PH_W-1:0]   p1_d;
  logic [PH_W-1:0]   p1_q;
  logic              v1_q;
  logic [LUT_AW-1:0] lut_addr;
  logic [MAG_W-1:0]  m2_q;
  logic              neg2_q;
  logic              v2_q;
  logic [OUT_W-1:0]  sample_d;
  logic [OUT_W-1:0]  sample_q;
  logic              v3_q;

  // Quarter-wave magnitudes: round(127*sin(pi*(2i+1)/256)); the half-step offset keeps 128 out of the output.
  function automatic logic [MAG_W-1:0] lutMag(input logic [LUT_AW-1:0] a);
    logic [MAG_W-1:0] m;
    m = '0;
    case (a)
      6'd0:  m = 7'd2;   6'd1:  m = 7'd5;   6'd2:  m = 7'd8;   6'd3:  m = 7'd11;
      6'd4:  m = 7'd14;  6'd5:  m = 7'd17;  6'd6:  m = 7'd20;  6'd7:  m = 7'd23;
      6'd8:  m = 7'd26;  6'd9:  m = 7'd29;  6'd10: m = 7'd32;  6'd11: m = 7'd35;
      6'd12: m = 7'd38;  6'd13: m = 7'd41;  6'd14: m = 7'd44;  6'd15: m = 7'd47;
      6'd16: m = 7'd50;  6'd17: m = 7'd53;  6'd18: m = 7'd56;  6'd19: m = 7'd58;
      6'd20: m = 7'd61;  6'd21: m = 7'd64;  6'd22: m = 7'd67;  6'd23: m = 7'd69;
      6'd24: m = 7'd72;  6'd25: m = 7'd74;  6'd26: m = 7'd77;  6'd27: m = 7'd79;
      6'd28: m = 7'd82;  6'd29: m = 7'd84;  6'd30: m = 7'd86;  6'd31: m = 7'd89;
      6'd32: m = 7'd91;  6'd33: m = 7'd93;  6'd34: m = 7'd95;  6'd35: m = 7'd97;
      6'd36: m = 7'd99;  6'd37: m = 7'd101; 6'd38: m = 7'd103; 6'd39: m = 7'd105;
      6'd40: m = 7'd106; 6'd41: m = 7'd108; 6'd42: m = 7'd110; 6'd43: m = 7'd111;
      6'd44: m = 7'd113; 6'd45: m = 7'd114; 6'd46: m = 7'd115; 6'd47: m = 7'd117;
      6'd48: m = 7'd118; 6'd49: m = 7'd119; 6'd50: m = 7'd120; 6'd51: m = 7'd121;
      6'd52: m = 7'd122; 6'd53: m = 7'd123; 6'd54: m = 7'd124; 6'd55: m = 7'd124;
      6'd56: m = 7'd125; 6'd57: m = 7'd125; 6'd58: m = 7'd126; 6'd59: m = 7'd126;
      6'd60: m = 7'd127; 6'd61: m = 7'd127; 6'd62: m = 7'd127; 6'd63: m = 7'd127;
    endcase
    return m;
  endfunction

  assign wr_en   = bus.cfg_valid & cfg_ready_q;
  assign clr_req = wr_en && (bus.cfg_addr == 2'd3) && bus.cfg_data[1];

  // Configuration registers; FTW_HI commits the shadowed low byte so frequency changes atomically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ready_q <= 1'b0;
      ftw_lo_q    <= '0;
      ftw_q       <= '0;
      phase_ofs_q <= '0;
      run_q       <= 1'b0;
    end else begin
      cfg_ready_q <= 1'b1;
      if (wr_en) begin
        case (bus.cfg_addr)
          ADDR_FTW_LO: ftw_lo_q    <= bus.cfg_data;
          ADDR_FTW_HI: ftw_q       <= {bus.cfg_data, ftw_lo_q};
          ADDR_PHASE:  phase_ofs_q <= bus.cfg_data;
          default:     run_q       <= bus.cfg_data[0];
        endcase
      end
    end
  end

  // Accumulator next state: a clear request wins over accumulation, and accumulation uses the ftw in force before this edge.
  always_comb begin
    acc_d = acc_q;
    if (clr_req) begin
      acc_d = '0;
    end else if (run_q) begin
      acc_d = acc_q + ftw_q;
    end
  end

  // Phase accumulator register, wrapping silently modulo 2^ACC_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Stage datapaths: phase offset add, quadrant folding of the table address, and sign application around mid-scale.
  always_comb begin
    p1_d     = acc_q[ACC_W-1 -: PH_W] + phase_ofs_q;
    lut_addr = p1_q[LUT_AW] ? ~p1_q[LUT_AW-1:0] : p1_q[LUT_AW-1:0];
    sample_d = neg2_q ? (MID_SCALE - {1'b0, m2_q}) : (MID_SCALE + {1'b0, m2_q});
  end

  // Three pipeline stages; data only advances alongside a set valid bit so the last sample is held after a stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q     <= '0;
      v1_q     <= 1'b0;
      m2_q     <= '0;
      neg2_q   <= 1'b0;
      v2_q     <= 1'b0;
      sample_q <= MID_SCALE;
      v3_q     <= 1'b0;
    end else begin
      v1_q <= run_q;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (run_q) begin
        p1_q <= p1_d;
      end
      if (v1_q) begin
        m2_q   <= lutMag(lut_addr);
        neg2_q <= p1_q[PH_W-1];
      end
      if (v2_q) begin
        sample_q <= sample_d;
      end
    end
  end

  assign bus.cfg_ready    = cfg_ready_q;
  assign bus.sample       = sample_q;
  assign bus.sample_valid = v3_q;
  assign bus.running      = run_q;

endmodule

// File: tb/tb_sine_dds_core.sv
// tb_sine_dds_core: directed, self-checking bench for the sine DDS core.
module tb_sine_dds_core;

  localparam logic [1:0] ADDR_FTW_LO = 2'd0;
  localparam logic [1:0] ADDR_FTW_HI = 2'd1;
  localparam logic [1:0] ADDR_PHASE  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sine_dds_core_if dif ();

  sine_dds_core dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  // Free-running 10-unit clock; the bench drives and samples on falling edges.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected sample for an 8-bit phase, taken straight from the sine formula rather than a table.
  function automatic int expSample(input int p);
    real s;
    real a;
    int  mag;
    s   = $sin(3.14159265358979 * real'(2 * (p % 256) + 1) / 256.0);
    a   = (s < 0.0) ? -s : s;
    mag = $rtoi(127.0 * a + 0.5);
    return (s < 0.0) ? (128 - mag) : (128 + mag);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkLive(input string tag, input int expected);
    checkOutput({tag, ".valid"}, 32'(dif.sample_valid), 32'd1);
    checkOutput({tag, ".sample"}, 32'(dif.sample), 32'(expected));
  endtask

  task automatic checkIdle(input string tag, input int heldSample);
    checkOutput({tag, ".valid"}, 32'(dif.sample_valid), 32'd0);
    checkOutput({tag, ".sample"}, 32'(dif.sample), 32'(heldSample));
  endtask

  // Called at a falling edge; presents one write across exactly one rising edge and returns at the next falling edge.
  task automatic applyStimulus(input logic [1:0] addr, input logic [7:0] data);
    dif.cfg_valid = 1'b1;
    dif.cfg_addr  = addr;
    dif.cfg_data  = data;
    @(negedge clk);
    dif.cfg_valid = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    dif.cfg_valid = 1'b0;
    dif.cfg_addr  = 2'd0;
    dif.cfg_data  = 8'd0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst.sample", 32'(dif.sample), 32'd128);
    checkOutput("rst.valid", 32'(dif.sample_valid), 32'd0);
    checkOutput("rst.running", 32'(dif.running), 32'd0);
    checkOutput("rst.ready", 32'(dif.cfg_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("release.ready", 32'(dif.cfg_ready), 32'd1);

    $display("[TB] FTW=0x0100 sweep");
    applyStimulus(ADDR_FTW_LO, 8'h00);
    applyStimulus(ADDR_FTW_HI, 8'h01);
    applyStimulus(ADDR_PHASE, 8'h00);
    applyStimulus(ADDR_CTRL, 8'h01);
    checkOutput("run.running", 32'(dif.running), 32'd1);
    checkIdle("run.e1", 128);
    tick();
    checkIdle("run.e2", 128);
    tick();
    checkIdle("run.e3", 128);
    for (int k = 0; k < 260; k++) begin
      tick();
      checkLive($sformatf("sweep%0d", k), expSample(k));
      if (k == 0)   checkOutput("sweep.first", 32'(dif.sample), 32'd130);
      if (k == 1)   checkOutput("sweep.second", 32'(dif.sample), 32'd133);
      if (k == 2)   checkOutput("sweep.third", 32'(dif.sample), 32'd136);
      if (k == 63)  checkOutput("sweep.peak", 32'(dif.sample), 32'd255);
      if (k == 128) checkOutput("sweep.halfway", 32'(dif.sample), 32'd126);
      if (k == 256) checkOutput("sweep.period0", 32'(dif.sample), 32'd130);
      if (k == 257) checkOutput("sweep.period1", 32'(dif.sample), 32'd133);
    end

    $display("[TB] FTW_LO write alone keeps the step");
    applyStimulus(ADDR_FTW_LO, 8'h00);
    checkLive("lo.p4", 142);
    tick(); checkLive("lo.p5", 145);
    tick(); checkLive("lo.p6", 148);
    tick(); checkLive("lo.p7", 151);

    $display("[TB] clear mid-stream");
    applyStimulus(ADDR_CTRL, 8'h03);
    checkLive("clr.drain0", 154);
    checkOutput("clr.running", 32'(dif.running), 32'd1);
    tick(); checkLive("clr.drain1", 157);
    tick(); checkLive("clr.drain2", 160);
    tick(); checkLive("clr.restart0", 130);
    tick(); checkLive("clr.restart1", 133);
    tick(); checkLive("clr.restart2", 136);

    $display("[TB] FTW_HI commit to 0x0200");
    applyStimulus(ADDR_FTW_HI, 8'h02);
    checkLive("hi.c0", 139);
    tick(); checkLive("hi.c1", 142);
    tick(); checkLive("hi.c2", 145);
    tick(); checkLive("hi.c3", 148);
    tick(); checkLive("hi.c4", 154);
    tick(); checkLive("hi.c5", 160);

    $display("[TB] stop and drain");
    applyStimulus(ADDR_CTRL, 8'h00);
    checkLive("stop.s0", 166);
    checkOutput("stop.running", 32'(dif.running), 32'd0);
    tick(); checkLive("stop.s1", 172);
    tick(); checkLive("stop.s2", 178);
    tick(); checkIdle("stop.s3", 178);
    tick(); checkIdle("stop.s4", 178);

    $display("[TB] phase offset 0x40");
    applyStimulus(ADDR_CTRL, 8'h02);
    checkIdle("frozen.clr", 178);
    checkOutput("frozen.running", 32'(dif.running), 32'd0);
    applyStimulus(ADDR_FTW_HI, 8'h01);
    applyStimulus(ADDR_PHASE, 8'h40);
    applyStimulus(ADDR_CTRL, 8'h01);
    checkIdle("ofs.e1", 178);
    tick(); checkIdle("ofs.e2", 178);
    tick(); checkIdle("ofs.e3", 178);
    tick(); checkLive("ofs.p40", 255);
    tick(); checkLive("ofs.p41", 255);
    tick(); checkLive("ofs.p42", 255);
    tick(); checkLive("ofs.p43", 255);
    tick(); checkLive("ofs.p44", 254);

    $display("[TB] FTW=0x8000 then FTW=0");
    applyStimulus(ADDR_CTRL, 8'h02);
    applyStimulus(ADDR_PHASE, 8'h00);
    applyStimulus(ADDR_FTW_HI, 8'h80);
    applyStimulus(ADDR_CTRL, 8'h01);
    tick();
    tick(); checkOutput("half.e2.valid", 32'(dif.sample_valid), 32'd0);
    tick(); checkLive("half.a0", 130);
    tick(); checkLive("half.a1", 126);
    tick(); checkLive("half.a2", 130);
    tick(); checkLive("half.a3", 126);
    applyStimulus(ADDR_FTW_HI, 8'h00);
    checkLive("zero.c0", 130);
    tick(); checkLive("zero.c1", 126);
    tick(); checkLive("zero.c2", 130);
    tick(); checkLive("zero.c3", 126);
    tick(); checkLive("zero.c4", 126);
    tick(); checkLive("zero.c5", 126);

    $display("[TB] asynchronous reset while running");
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst.sample", 32'(dif.sample), 32'd128);
    checkOutput("arst.valid", 32'(dif.sample_valid), 32'd0);
    checkOutput("arst.running", 32'(dif.running), 32'd0);
    checkOutput("arst.ready", 32'(dif.cfg_ready), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    checkOutput("arst.ready_back", 32'(dif.cfg_ready), 32'd1);
    checkOutput("arst.running_off", 32'(dif.running), 32'd0);
    tick();
    tick();
    tick(); checkIdle("arst.idle", 128);
    applyStimulus(ADDR_FTW_HI, 8'h01);
    applyStimulus(ADDR_CTRL, 8'h01);
    tick();
    tick(); checkIdle("rerun.e3", 128);
    tick(); checkLive("rerun.s0", 130);
    tick(); checkLive("rerun.s1", 133);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sine_dds_core.md
Name: sine_dds_core

Overview:
Direct digital synthesis core that sits directly upstream of the Tiny Tapeout top wrapper. It generates an 8-bit offset-binary sine sample stream from a 16-bit phase accumulator and a quarter-wave lookup table. The top maps sample onto uo_out. The top also drives the byte-wide configuration bus from its dedicated and bidirectional input pins.

Parameters:
ACC_W, 16, phase accumulator width. Phase is taken from acc[ACC_W-1:ACC_W-8].
OUT_W, 8, sample width. Offset binary, mid-scale 128.
LUT_AW, 6, quarter-wave table address width (64 entries).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  configuration write request
cfg_ready  output  1  configuration write accept
cfg_addr  input  2  register select: 0 FTW_LO, 1 FTW_HI, 2 PHASE_OFS, 3 CTRL
cfg_data  input  8  write data
sample  output  8  sine sample, offset binary
sample_valid  output  1  high while sample carries a live pipeline value
running  output  1  mirror of CTRL.run

Behaviour:
- One clock domain (clk). Reset is asynchronous and active-low (rst_n). All state clears immediately on rst_n low, including mid-operation.
- Reset values:
  - ftw, ftw_lo_shadow, phase_ofs, acc, run, pipeline registers = 0
  - sample = 128, sample_valid = 0, running = 0, cfg_ready = 0
- cfg_ready = 1 on every cycle after reset is released. A write is accepted on any rising edge with cfg_valid & cfg_ready.
- FTW_LO write: loads ftw_lo_shadow only. Active ftw is unchanged.
- FTW_HI write: active ftw <= {cfg_data, ftw_lo_shadow} on the same edge (atomic commit). Writing FTW_LO alone never changes frequency.
- PHASE_OFS write: 8-bit offset, effective from the next accumulator sample.
- CTRL write:
  - bit0 run: level, held.
  - bit1 clr: self-clearing. acc <= 0 on that edge, overriding the accumulate.
  - bits 7:2 ignored.
  - run=0 together with clr=1: acc cleared and frozen.
- Accumulator: when run=1, acc <= acc + ftw, modulo 2^16 (wrap silently). When run=0, acc holds.
- Pipeline (3 register stages, all gated by a valid bit that shifts with the data):
  - S1: p = acc[15:8] + phase_ofs, mod 256, registered with v1 = run.
  - S2: quadrant q = p[7:6], idx = p[5:0]. Table address = idx for q even, 63-idx for q odd. Registered: magnitude m = LUT[addr], neg = q[1], v2 = v1.
  - S3: sample = neg ? 128-m : 128+m; sample_valid = v2.
- LUT: m[i] = round(127*sin(pi*(2i+1)/256)), i = 0..63. Examples: m[0]=2, m[1]=5, m[2]=8, m[63]=127. Output range is 1..255; 128 is never produced while valid.
- Latency: the acc value present at edge E appears on sample after edge E+3.
  - First sample_valid=1 follows the third edge after the edge that set run. That sample carries the pre-increment acc value.
- Stop: after run goes 0, valid bits drain. sample_valid falls 3 edges later. sample holds its last value (no return to 128).
- FTW=0: constant sample, sample_valid stays high.
- Simultaneous FTW_HI commit and accumulate on the same edge: the accumulate uses the old ftw. The new ftw applies from the next edge.

Test Plan:
- Reset, then FTW_LO=0x00, FTW_HI=0x01, CTRL=0x01 -> sample_valid rises 3 edges after the run edge. Samples are 130, 133, 136, ...; the 64th sample is 255; the period is exactly 256 samples.
- Same setup with PHASE_OFS=0x40 written before run -> first valid sample is 255 (q=1, idx 0 maps to m[63]=127).
- FTW=0x8000 -> samples alternate between the p=0x00 and p=0x80 values: 130, 126, 130, 126, ...
- Write FTW_LO=0x00 while running at FTW=0x0100, then hold several cycles -> step size unchanged. Then FTW_HI=0x02 -> step becomes 2 LUT positions; the first sample at the new step appears 4 edges after the commit edge.
- CTRL=0x03 mid-stream -> acc cleared. The next 3 samples drain the old phases, then the sequence restarts 130, 133. CTRL=0x00 -> sample_valid falls after 3 edges and sample freezes.
- Assert rst_n low asynchronously between clock edges while running -> sample=128, sample_valid=0, running=0, cfg_ready=0 immediately. After release, no output until run is rewritten.
